// File: rtl/param_shift_reg_pkg.sv
// shift_reg_pkg: mode encodings and Fill-width helper shared by the shift register slice
package shift_reg_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_FWD  = 2'b01;
    localparam logic [1:0] MODE_REV  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    // Fill has to represent 0..DEPTH inclusive.
    function automatic int fill_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/param_shift_reg_if.sv
// param_shift_reg_if: control, data and status bundle for param_shift_reg
//   master (driver): En, Mode, Din, Vin, LoadData, [Clr] out; Qout, Vout, QoutRev, VoutRev, Taps, Fill, Full in
//   slave  (block) : the reverse
//   Clr exists only when SHIFT_REG_SCLR_EN is defined.
interface param_shift_reg_if import shift_reg_pkg::*; #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) ();
    logic                        En;
    logic [1:0]                  Mode;
    logic [WIDTH-1:0]            Din;
    logic                        Vin;
    logic [DEPTH*WIDTH-1:0]      LoadData;
`ifdef SHIFT_REG_SCLR_EN
    logic                        Clr;
`endif
    logic [WIDTH-1:0]            Qout;
    logic                        Vout;
    logic [WIDTH-1:0]            QoutRev;
    logic                        VoutRev;
    logic [DEPTH*WIDTH-1:0]      Taps;
    logic [fill_w(DEPTH)-1:0]    Fill;
    logic                        Full;

    modport master (
        output En, Mode, Din, Vin, LoadData,
`ifdef SHIFT_REG_SCLR_EN
        output Clr,
`endif
        input  Qout, Vout, QoutRev, VoutRev, Taps, Fill, Full
    );

    modport slave (
        input  En, Mode, Din, Vin, LoadData,
`ifdef SHIFT_REG_SCLR_EN
        input  Clr,
`endif
        output Qout, Vout, QoutRev, VoutRev, Taps, Fill, Full
    );
endinterface

// File: rtl/param_shift_reg_stage.sv
// shift_stage: one WIDTH-bit data register plus valid bit with async reset and load enable
//   Clk, Reset : clock, async active-high reset
//   en         : capture d/vd on the rising edge
//   d, vd      : selected next data / valid
//   q, v       : registered data / valid
module shift_stage import shift_reg_pkg::*; #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    input  logic             vd,
    output logic [WIDTH-1:0] q,
    output logic             v
);
    always_ff @(posedge Clk or posedge Reset)
        if (Reset) begin
            q <= '0;
            v <= 1'b0;
        end else if (en) begin
            q <= d;
            v <= vd;
        end
endmodule

// File: rtl/param_shift_reg.sv
// param_shift_reg: DEPTH-stage WIDTH-bit shift register with valid bits, forward/reverse shift, parallel load, hold
//   Clk, Reset : clock, async active-high reset
//   bus        : param_shift_reg_if slave (En, Mode, Din, Vin, LoadData, [Clr] in; Qout, Vout, QoutRev, VoutRev, Taps, Fill, Full out)
//   SHIFT_REG_SCLR_EN : adds synchronous clear Clr, which beats En and Mode
module param_shift_reg import shift_reg_pkg::*; #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    param_shift_reg_if.slave bus
);
    localparam int FW = fill_w(DEPTH);

    logic [DEPTH*WIDTH-1:0] taps, fwd, rev, nd;
    logic [DEPTH-1:0]       v, vf, vr, nv;
    logic [FW-1:0]          fill;
    logic                   clr, adv;

`ifdef SHIFT_REG_SCLR_EN
    assign clr = bus.Clr;
`else
    assign clr = 1'b0;
`endif

    // Neighbour images: forward pulls from the stage below (Din into stage 0),
    // reverse pulls from the stage above (Din into stage DEPTH-1).
    assign fwd = {taps[(DEPTH-1)*WIDTH-1:0], bus.Din};
    assign rev = {bus.Din, taps[DEPTH*WIDTH-1:WIDTH]};
    assign vf  = {v[DEPTH-2:0], bus.Vin};
    assign vr  = {bus.Vin, v[DEPTH-1:1]};

    assign adv = clr | (bus.En & (bus.Mode != MODE_HOLD));

    always_comb begin
        nd = clr ? '0 : bus.Mode == MODE_FWD ? fwd : bus.Mode == MODE_REV ? rev : bus.LoadData;
        nv = clr ? '0 : bus.Mode == MODE_FWD ? vf  : bus.Mode == MODE_REV ? vr  : '1;
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        shift_stage #(.WIDTH(WIDTH)) u_stage (
            .Clk   (Clk),
            .Reset (Reset),
            .en    (adv),
            .d     (nd[g*WIDTH +: WIDTH]),
            .vd    (nv[g]),
            .q     (taps[g*WIDTH +: WIDTH]),
            .v     (v[g])
        );
    end

    always_comb begin
        fill = '0;
        for (int i = 0; i < DEPTH; i++)
            fill = fill + FW'(v[i]);
    end

    assign bus.Qout    = taps[(DEPTH-1)*WIDTH +: WIDTH];
    assign bus.Vout    = v[DEPTH-1];
    assign bus.QoutRev = taps[WIDTH-1:0];
    assign bus.VoutRev = v[0];
    assign bus.Taps    = taps;
    assign bus.Fill    = fill;
    assign bus.Full    = fill == FW'(DEPTH);
endmodule

// File: tb/tb_param_shift_reg.sv
// tb_param_shift_reg: directed self-checking bench for param_shift_reg (WIDTH=8, DEPTH=4)
module tb_param_shift_reg;
    import shift_reg_pkg::*;

    logic Clk = 1'b0;
    logic Reset;
    int   checks = 0;
    int   errors = 0;

    param_shift_reg_if #(.WIDTH(8), .DEPTH(4)) bus ();

    param_shift_reg #(.WIDTH(8), .DEPTH(4)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step(input logic [1:0] m, input logic [7:0] d, input logic vi);
        bus.Mode = m;
        bus.Din  = d;
        bus.Vin  = vi;
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Reset        = 1'b1;
        bus.En       = 1'b0;
        bus.Mode     = MODE_HOLD;
        bus.Din      = '0;
        bus.Vin      = 1'b0;
        bus.LoadData = '0;
`ifdef SHIFT_REG_SCLR_EN
        bus.Clr      = 1'b0;
`endif
        repeat (2) @(posedge Clk);
        #1;
        chk("rst_taps", bus.Taps, 32'h0);
        chk("rst_fill", 32'(bus.Fill), 32'd0);
        chk("rst_vout", 32'(bus.Vout), 32'd0);
        Reset = 1'b0;

        bus.En = 1'b1;
        step(MODE_FWD, 8'h11, 1'b1);
        step(MODE_FWD, 8'h22, 1'b1);
        step(MODE_FWD, 8'h33, 1'b1);
        chk("fwd3_vout", 32'(bus.Vout), 32'd0);
        step(MODE_FWD, 8'h44, 1'b1);
        chk("fwd4_qout", 32'(bus.Qout), 32'h11);
        chk("fwd4_vout", 32'(bus.Vout), 32'd1);
        chk("fwd4_full", 32'(bus.Full), 32'd1);
        chk("fwd4_taps", bus.Taps, 32'h11223344);
        step(MODE_FWD, 8'h55, 1'b1);
        chk("fwd5_qout", 32'(bus.Qout), 32'h22);
        chk("fwd5_taps", bus.Taps, 32'h22334455);

        #2 Reset = 1'b1;
        #1;
        chk("arst_taps", bus.Taps, 32'h0);
        chk("arst_fill", 32'(bus.Fill), 32'd0);
        chk("arst_full", 32'(bus.Full), 32'd0);
        Reset = 1'b0;

        step(MODE_FWD, 8'h11, 1'b1);
        step(MODE_FWD, 8'h22, 1'b1);
        bus.En = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(MODE_FWD, 8'h77, 1'b1);
            chk("stall_fill", 32'(bus.Fill), 32'd2);
        end
        chk("stall_taps", bus.Taps, 32'h00001122);
        bus.En = 1'b1;
        step(MODE_FWD, 8'h33, 1'b1);
        chk("stall6_vout", 32'(bus.Vout), 32'd0);
        step(MODE_FWD, 8'h44, 1'b1);
        chk("stall7_qout", 32'(bus.Qout), 32'h11);
        chk("stall7_vout", 32'(bus.Vout), 32'd1);

        step(MODE_HOLD, 8'h99, 1'b1);
        chk("hold_taps", bus.Taps, 32'h11223344);
        bus.En = 1'b0;
        bus.LoadData = 32'hCAFEF00D;
        step(MODE_LOAD, 8'h00, 1'b0);
        chk("en0_load_taps", bus.Taps, 32'h11223344);

        bus.En = 1'b1;
        bus.LoadData = 32'hA3A2A1A0;
        step(MODE_LOAD, 8'h00, 1'b0);
        chk("load_taps", bus.Taps, 32'hA3A2A1A0);
        chk("load_full", 32'(bus.Full), 32'd1);
        step(MODE_REV, 8'hFF, 1'b0);
        chk("rev_qoutrev", 32'(bus.QoutRev), 32'hA1);
        chk("rev_taps", bus.Taps, 32'hFFA3A2A1);
        chk("rev_fill", 32'(bus.Fill), 32'd3);
        chk("rev_vout", 32'(bus.Vout), 32'd0);
        chk("rev_voutrev", 32'(bus.VoutRev), 32'd1);
        step(MODE_FWD, 8'h5A, 1'b1);
        chk("turn_taps", bus.Taps, 32'hA3A2A15A);
        chk("turn_qout", 32'(bus.Qout), 32'hA3);
        chk("turn_fill", 32'(bus.Fill), 32'd4);

        #2 Reset = 1'b1;
        #1 Reset = 1'b0;
        step(MODE_FWD, 8'h01, 1'b1);
        step(MODE_FWD, 8'h02, 1'b0);
        step(MODE_FWD, 8'h03, 1'b1);
        step(MODE_FWD, 8'h04, 1'b0);
        chk("pv4_fill", 32'(bus.Fill), 32'd2);
        chk("pv4_vout", 32'(bus.Vout), 32'd1);
        chk("pv4_qout", 32'(bus.Qout), 32'h01);
        step(MODE_FWD, 8'h05, 1'b0);
        chk("pv5_fill", 32'(bus.Fill), 32'd1);
        chk("pv5_vout", 32'(bus.Vout), 32'd0);
        chk("pv5_qout", 32'(bus.Qout), 32'h02);

        bus.LoadData = 32'h12345678;
        step(MODE_LOAD, 8'h00, 1'b0);
        chk("pre_clr_full", 32'(bus.Full), 32'd1);
        bus.LoadData = 32'hDEADBEEF;
`ifdef SHIFT_REG_SCLR_EN
        bus.Clr = 1'b1;
        step(MODE_LOAD, 8'h00, 1'b0);
        bus.Clr = 1'b0;
        chk("clr_taps", bus.Taps, 32'h0);
        chk("clr_fill", 32'(bus.Fill), 32'd0);
`else
        step(MODE_LOAD, 8'h00, 1'b0);
        chk("noclr_taps", bus.Taps, 32'hDEADBEEF);
        chk("noclr_fill", 32'(bus.Fill), 32'd4);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
